// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: loads PC-1(key) on start and emits one PC-2 subkey per handshake.
// Optional odd-parity key check is compiled in with `DES_KEY_PARITY_CHECK_EN.
module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [64:1] key,
  input  logic        decrypt,
  input  logic        key_ready,
  output logic [48:1] subkey,
  output logic        subkey_valid,
  output logic [4:0]  round,
  output logic        last,
  output logic        busy,
  output logic        parity_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_decrypt;
  logic [4:0]  r_round;
  logic        r_last;

  logic [55:0] w_pc1;
  logic [55:0] w_cd;
  logic [4:0]  w_sidx;
  logic        w_two;
  logic        w_key_ok;
  logic        w_accept;

  function automatic logic shift_is_two(input logic [4:0] idx);
    logic res;
    case (idx)
      5'd1, 5'd2, 5'd9, 5'd16: res = 1'b0;
      default:                 res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
    logic [27:0] res;
    if (two) begin
      res = {h[25:0], h[27:26]};
    end else begin
      res = {h[26:0], h[27]};
    end
    return res;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
    logic [27:0] res;
    if (two) begin
      res = {h[1:0], h[27:2]};
    end else begin
      res = {h[0], h[27:1]};
    end
    return res;
  endfunction

  // PC-1: bit 55 is C bit 1, bit 0 is D bit 28; key[65-n] holds DES bit n.
  assign w_pc1 = {key[8],  key[16], key[24], key[32], key[40], key[48], key[56], key[64],
                  key[7],  key[15], key[23], key[31], key[39], key[47], key[55], key[63],
                  key[6],  key[14], key[22], key[30], key[38], key[46], key[54], key[62],
                  key[5],  key[13], key[21], key[29],
                  key[2],  key[10], key[18], key[26], key[34], key[42], key[50], key[58],
                  key[3],  key[11], key[19], key[27], key[35], key[43], key[51], key[59],
                  key[4],  key[12], key[20], key[28], key[36], key[44], key[52], key[60],
                  key[37], key[45], key[53], key[61]};

  // PC-2 straight off the C/D registers; CD bit n sits at w_cd[56-n].
  assign w_cd   = {r_c, r_d};
  assign subkey = {w_cd[42], w_cd[39], w_cd[45], w_cd[32], w_cd[55], w_cd[51], w_cd[53], w_cd[28],
                   w_cd[41], w_cd[50], w_cd[35], w_cd[46], w_cd[33], w_cd[37], w_cd[44], w_cd[52],
                   w_cd[30], w_cd[48], w_cd[40], w_cd[49], w_cd[29], w_cd[36], w_cd[43], w_cd[54],
                   w_cd[15], w_cd[4],  w_cd[25], w_cd[19], w_cd[9],  w_cd[1],  w_cd[26], w_cd[16],
                   w_cd[5],  w_cd[11], w_cd[23], w_cd[8],  w_cd[12], w_cd[7],  w_cd[17], w_cd[0],
                   w_cd[22], w_cd[3],  w_cd[10], w_cd[14], w_cd[6],  w_cd[20], w_cd[27], w_cd[24]};

  logic w_unused_cd;
  assign w_unused_cd = ^{w_cd[47], w_cd[38], w_cd[34], w_cd[31],
                         w_cd[21], w_cd[18], w_cd[13], w_cd[2]};

  // Decrypt walks the shift table backwards, so the step after round r uses s(17-r).
  assign w_sidx   = r_decrypt ? (5'd17 - r_round) : (r_round + 5'd1);
  assign w_two    = shift_is_two(w_sidx);
  assign w_accept = (r_state == S_IDLE) && start && w_key_ok;

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic key_parity_ok(input logic [64:1] k);
    return (^k[64:57]) & (^k[56:49]) & (^k[48:41]) & (^k[40:33]) &
           (^k[32:25]) & (^k[24:17]) & (^k[16:9])  & (^k[8:1]);
  endfunction

  logic r_parity_err;

  assign w_key_ok   = key_parity_ok(key);
  assign parity_err = r_parity_err;

  // One-cycle pulse for a start that is refused because of a bad key byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (r_state == S_IDLE) && start && !w_key_ok;
    end
  end
`else
  logic w_unused_key_parity;

  assign w_key_ok            = 1'b1;
  assign parity_err          = 1'b0;
  assign w_unused_key_parity = ^{key[57], key[49], key[41], key[33],
                                 key[25], key[17], key[9],  key[1]};
`endif

  // Schedule FSM: loads C/D on accept, rotates them on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_c       <= 28'd0;
      r_d       <= 28'd0;
      r_decrypt <= 1'b0;
      r_round   <= 5'd0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_RUN;
            r_decrypt <= decrypt;
            r_round   <= 5'd1;
            r_last    <= 1'b0;
            if (decrypt) begin
              r_c <= w_pc1[55:28];
              r_d <= w_pc1[27:0];
            end else begin
              r_c <= rotl(w_pc1[55:28], 1'b0);
              r_d <= rotl(w_pc1[27:0], 1'b0);
            end
          end else begin
            r_round <= 5'd0;
            r_last  <= 1'b0;
          end
        end
        S_RUN: begin
          if (key_ready) begin
            if (r_round == 5'd16) begin
              r_state <= S_IDLE;
              r_round <= 5'd0;
              r_last  <= 1'b0;
            end else begin
              r_round <= r_round + 5'd1;
              r_last  <= (r_round == 5'd15);
              if (r_decrypt) begin
                r_c <= rotr(r_c, w_two);
                r_d <= rotr(r_d, w_two);
              end else begin
                r_c <= rotl(r_c, w_two);
                r_d <= rotl(r_d, w_two);
              end
            end
          end else begin
            r_round <= r_round;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_round <= 5'd0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign subkey_valid = (r_state == S_RUN);
  assign busy         = (r_state == S_RUN);
  assign round        = r_round;
  assign last         = r_last;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench for des_key_sched_seq: table of full schedules plus stall,
// back-to-back, mid-schedule reset and parity corner cases.
module tb_des_key_sched_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [64:1] key;
  logic        decrypt;
  logic        key_ready;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic [4:0]  round;
  logic        last;
  logic        busy;
  logic        parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  des_key_sched_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key          (key),
    .decrypt      (decrypt),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .last         (last),
    .busy         (busy),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [64:1] k;
    logic        dec;
    logic [48:1] k1;
    logic [48:1] k2;
    logic [48:1] k16;
  } vec_t;

  vec_t tbl[6];

  localparam logic [64:1] MAIN_KEY = 64'h133457799BBCDFF1;
  localparam logic [48:1] MAIN_K1  = 48'h1B02EFFC7072;
  localparam logic [48:1] MAIN_K2  = 48'h79AED9DBC9E5;
  localparam logic [48:1] MAIN_K16 = 48'hCB3D8B0E17F5;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [64:1] k, input logic dec);
    @(negedge clk);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Walks the rest of a schedule with key_ready high; expects to be at round 1.
  task automatic run_schedule(input vec_t v);
    int  cnt;
    bit  done;
    logic [48:1] exp_r1, exp_r16, exp_x;
    int  x_round;
    cnt  = 0;
    done = 1'b0;
    key_ready = 1'b1;
    exp_r1  = v.dec ? v.k16 : v.k1;
    exp_r16 = v.dec ? v.k1  : v.k16;
    exp_x   = v.k2;
    x_round = v.dec ? 15 : 2;
    for (int c = 0; c < 40 && !done; c++) begin
      if (subkey_valid) begin
        cnt++;
        chk("round_seq", 64'(round), 64'(cnt));
        chk("last_flag", 64'(last), 64'(cnt == 16));
        if (cnt == 1) begin
          chk("subkey_r1", 64'(subkey), 64'(exp_r1));
          chk("busy_run", 64'(busy), 64'd1);
        end
        if (cnt == x_round) chk("subkey_k2", 64'(subkey), 64'(exp_x));
        if (cnt == 16) chk("subkey_r16", 64'(subkey), 64'(exp_r16));
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk("valid_count", 64'(cnt), 64'd16);
    chk("busy_after", 64'(busy), 64'd0);
    chk("round_after", 64'(round), 64'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    key_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!subkey_valid) done = 1'b1;
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{MAIN_KEY, 1'b0, MAIN_K1, MAIN_K2, MAIN_K16};
    tbl[1] = '{MAIN_KEY, 1'b1, MAIN_K1, MAIN_K2, MAIN_K16};
    tbl[2] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    tbl[3] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    tbl[4] = '{64'h0101010101010101, 1'b0, 48'h0, 48'h0, 48'h0};
    tbl[5] = '{64'h0101010101010101, 1'b1, 48'h0, 48'h0, 48'h0};

    rst_n = 1'b0; start = 1'b0; key = 64'h0; decrypt = 1'b0; key_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perr", 64'(parity_err), 64'd0);

    // key_ready while idle must not start anything
    key_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", 64'(subkey_valid), 64'd0);
    end

    for (int i = 0; i < 6; i++) begin
      key_ready = 1'b1;
      do_start(tbl[i].k, tbl[i].dec);
      run_schedule(tbl[i]);
    end

    // Stall on round 1 while start/key wiggle
    key_ready = 1'b0;
    do_start(MAIN_KEY, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_subkey", 64'(subkey), 64'(MAIN_K1));
      chk("stall_round", 64'(round), 64'd1);
      start   = ~start;
      key     = {$urandom, $urandom};
      decrypt = ~decrypt;
      @(negedge clk);
    end
    start = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    chk("stall_r2_subkey", 64'(subkey), 64'(MAIN_K2));
    chk("stall_r2_round", 64'(round), 64'd2);
    drain();

    // Back-to-back: start raised while round 16 is being handed over
    key_ready = 1'b1;
    do_start(MAIN_KEY, 1'b0);
    for (int c = 0; c < 40 && !(subkey_valid && round == 5'd16); c++) @(negedge clk);
    chk("b2b_reach16", 64'(round), 64'd16);
    start = 1'b1; key = 64'hFEFEFEFEFEFEFEFE; decrypt = 1'b1;
    @(negedge clk);
    chk("b2b_gap_valid", 64'(subkey_valid), 64'd0);
    chk("b2b_gap_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_new_valid", 64'(subkey_valid), 64'd1);
    chk("b2b_new_round", 64'(round), 64'd1);
    chk("b2b_new_subkey", 64'(subkey), 64'hFFFFFFFFFFFF);
    drain();

    // Asynchronous reset at round 7
    key_ready = 1'b1;
    do_start(MAIN_KEY, 1'b0);
    for (int c = 0; c < 40 && round != 5'd7; c++) @(negedge clk);
    chk("arst_at7", 64'(round), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_subkey", 64'(subkey), 64'd0);
    chk("arst_valid", 64'(subkey_valid), 64'd0);
    chk("arst_round", 64'(round), 64'd0);
    chk("arst_last", 64'(last), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_perr", 64'(parity_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("arst_quiet", 64'(subkey_valid), 64'd0);
    end

    // All-zero key: even parity in every byte
    key_ready = 1'b1;
    do_start(64'h0, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("perr_pulse", 64'(parity_err), 64'd1);
    chk("perr_novalid", 64'(subkey_valid), 64'd0);
    @(negedge clk);
    chk("perr_clear", 64'(parity_err), 64'd0);
    chk("perr_novalid2", 64'(subkey_valid), 64'd0);
`else
    chk("noperr_flag", 64'(parity_err), 64'd0);
    chk("noperr_valid", 64'(subkey_valid), 64'd1);
    chk("noperr_subkey", 64'(subkey), 64'd0);
    drain();
    chk("noperr_flag2", 64'(parity_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_sched_seq.md
DES_KEY_SCHED_SEQ -- requirements
Module: des_key_sched_seq

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 `clk  in  1  rising-edge clock for all state.`
REQ-004 `rst_n  in  1  asynchronous, active-low reset.`
REQ-005 `start  in  1  requests a schedule; sampled only in IDLE.`
REQ-006 `key  in  [64:1]  DES key; key[64] is DES bit 1; parity bits are key[57], key[49], ... key[1].`
REQ-007 `decrypt  in  1  0 = emit K1..K16; 1 = emit K16..K1; sampled with start.`
REQ-008 `key_ready  in  1  consumer accepts subkey this cycle.`
REQ-009 `subkey  out  [48:1]  current PC-2 subkey; subkey[48] is PC-2 output bit 1.`
REQ-010 `subkey_valid  out  1  subkey is valid.`
REQ-011 `round  out  [4:0]  1..16 = position of subkey in the emitted sequence; 0 in IDLE.`
REQ-012 `last  out  1  subkey_valid & (round == 16).`
REQ-013 `busy  out  1  high in RUN.`
REQ-014 `parity_err  out  1  one-cycle pulse on a rejected key.`

Function
REQ-015 SHALL implement a 2-state FSM, IDLE and RUN.
- IDLE -> RUN on start = 1 with the key accepted.
- RUN -> IDLE on the handshake of round 16.
REQ-016 On accepting start, SHALL register C/D = PC-1(key).
- decrypt = 0: each half rotated left by 1.
- decrypt = 1: unrotated, equivalent to a total left shift of 28.
- decrypt SHALL also be latched.
REQ-017 subkey SHALL be PC-2(C,D) driven directly from the registers; subkey_valid = 1 and round = 1 in the cycle after start is accepted (latency 1).
REQ-018 A handshake occurs on a rising edge with subkey_valid & key_ready; without a handshake, subkey, round and subkey_valid SHALL hold stable.
REQ-019 Encrypt handshake at round r < 16: rotate C and D left by s(r+1), then round <= r+1.
- s(i) = 1 for i in {1, 2, 9, 16}.
- s(i) = 2 otherwise.
REQ-020 Decrypt handshake at round r < 16: rotate C and D right by s(17-r), then round <= r+1.
REQ-021 Handshake at round 16: go to IDLE; subkey_valid, busy and round SHALL clear in the next cycle.
REQ-022 start while in RUN SHALL be ignored; key and decrypt changes during RUN SHALL have no effect.
REQ-023 Back-to-back: start asserted in the cycle the FSM returns to IDLE SHALL be accepted, giving at least one idle cycle between schedules.
REQ-024 key_ready in IDLE SHALL be ignored.
REQ-025 One full schedule with key_ready held high SHALL take exactly 16 valid cycles.

Reset
REQ-026 With rst_n = 0, SHALL immediately force IDLE.
- C = D = 0 and the latched decrypt = 0.
- subkey = PC-2(0) = 0.
- subkey_valid = 0, round = 0, last = 0, busy = 0, parity_err = 0.
REQ-027 Reset mid-schedule SHALL abort it; after release, no subkey SHALL appear without a new start.

Configuration
REQ-028 Macro DES_KEY_PARITY_CHECK_EN.
- Defined: each key byte SHALL be checked for odd parity. On start with any byte of even parity, the FSM stays in IDLE, emits no subkey, and pulses parity_err high for exactly the next cycle.
- Undefined: parity_err SHALL be tied to 0 and every start in IDLE SHALL be accepted.

Verification
REQ-029 key = 0x133457799BBCDFF1, decrypt = 0, start 1 cycle, key_ready = 1:
- first valid cycle: subkey = 0x1B02EFFC7072, round = 1.
- then subkey = 0x79AED9DBC9E5, round = 2.
- round 16: subkey = 0xCB3D8B0E17F5, last = 1.
REQ-030 Same key, decrypt = 1: round 1 gives subkey = 0xCB3D8B0E17F5; round 16 gives 0x1B02EFFC7072 with last = 1; busy = 0 one cycle later.
REQ-031 Same key, decrypt = 0, key_ready = 0 for 5 cycles after the first valid: subkey stays 0x1B02EFFC7072 and round = 1 for those 5 cycles.
- Toggle start and key during that time: no change.
REQ-032 rst_n low at round 7 of an encrypt schedule: all outputs go to 0 asynchronously; after release, subkey_valid stays 0 for 20 cycles.
REQ-033 With DES_KEY_PARITY_CHECK_EN, key = 0x0000000000000000, start: parity_err = 1 for one cycle and subkey_valid stays 0.
- Without the macro: the same stimulus starts a schedule and parity_err stays 0.
